// File: rtl/fir_tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_pkg
//  Description : Shared types and width helpers for the time-multiplexed FIR
//                (controller state encoding, ceil-log2, accumulator width).
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_tdm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MAC  = 2'd2
   } state_t;

   // Ceiling log2; returns 0 for a value of 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Accumulator must hold TAPS full-precision products without overflow.
   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + clog2(taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tdm_mac.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_mac
//  Description : Shared signed multiplier-accumulator and output stage of the
//                FIR. The final sum is arithmetically shifted right by SHIFT
//                and either wrapped to OUT_W bits or, when FIR_SAT_EN is
//                defined, saturated to the signed OUT_W range.
//  Macro       : FIR_SAT_EN (optional saturation of the output value)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_mac
   import fir_tdm_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 18,
   parameter int OUT_W  = 11,
   parameter int SHIFT  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              last,
   input  logic [DATA_W-1:0] x_in,
   input  logic [COEF_W-1:0] c_in,
   output logic [OUT_W-1:0]  out_data
);

   localparam int PROD_W = DATA_W + COEF_W;
   localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

`ifdef FIR_SAT_EN
   localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [EXT_W-1:0]  shifted_ext;
   logic [OUT_W-1:0]         result;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;

   // Product, running sum and output formatting of the final sum.
   always_comb begin
      prod        = $signed(x_in) * $signed(c_in);
      sum         = acc_q + ACC_W'(prod);
      shifted     = sum >>> SHIFT;
      shifted_ext = EXT_W'(shifted);
`ifdef FIR_SAT_EN
      if (shifted_ext > SAT_MAX) begin
         result = OUT_W'(SAT_MAX);
      end else if (shifted_ext < SAT_MIN) begin
         result = OUT_W'(SAT_MIN);
      end else begin
         result = OUT_W'(shifted_ext);
      end
`else
      result = OUT_W'(shifted_ext);
`endif
      acc_d      = acc_q;
      out_data_d = out_data_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum;
         if (last) out_data_d = result;
      end
   end

   // Accumulator and output holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q      <= '0;
         out_data_q <= '0;
      end else begin
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_data = out_data_q;

endmodule
`default_nettype wire

// File: rtl/fir_tdm_core.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tdm_core
//  Description : Time-multiplexed signed FIR filter. One MAC per clock walks
//                all TAPS per sample; coefficients load through a burst;
//                valid/ready handshakes on input and output.
//  Macro       : FIR_SAT_EN (saturating output, handled in fir_tdm_mac)
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tdm_core
   import fir_tdm_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 11,
   parameter int SHIFT  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              coef_start,
   input  logic              coef_valid,
   input  logic [COEF_W-1:0] coef_data,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data
);

   localparam int              ACC_W    = acc_width(DATA_W, COEF_W, TAPS);
   localparam int              IDX_W    = clog2(TAPS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  wptr_q, wptr_d;
   logic [DATA_W-1:0] x_q [TAPS];
   logic [DATA_W-1:0] x_d [TAPS];
   logic [COEF_W-1:0] c_q [TAPS];
   logic [COEF_W-1:0] c_d [TAPS];
   logic              out_valid_q, out_valid_d;
   logic              accept;
   logic              mac_en;
   logic              mac_last;

   // Controller: next state, delay line, coefficient bank and handshakes.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      wptr_d      = wptr_q;
      x_d         = x_q;
      c_d         = c_q;
      out_valid_d = out_valid_q && !out_ready;
      accept      = 1'b0;
      mac_en      = 1'b0;
      mac_last    = (idx_q == LAST_IDX);
      // A new sample only starts if the result slot is free or being freed.
      in_ready    = (state_q == IDLE) && !coef_start && (!out_valid_q || out_ready);
      case (state_q)
         IDLE: begin
            if (coef_start) begin
               state_d = LOAD;
               wptr_d  = '0;
            end else if (in_valid && in_ready) begin
               accept = 1'b1;
               x_d[0] = in_data;
               for (int k = 1; k < TAPS; k++) begin
                  x_d[k] = x_q[k-1];
               end
               idx_d   = '0;
               state_d = MAC;
            end
         end
         LOAD: begin
            if (coef_valid) begin
               c_d[wptr_q] = coef_data;
               wptr_d      = wptr_q + 1'b1;
               if (wptr_q == LAST_IDX) state_d = IDLE;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (mac_last) begin
               idx_d       = '0;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointers, delay line, coefficients and output-valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wptr_q      <= '0;
         out_valid_q <= 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            x_q[k] <= '0;
            c_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wptr_q      <= wptr_d;
         out_valid_q <= out_valid_d;
         x_q         <= x_d;
         c_q         <= c_d;
      end
   end

   fir_tdm_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept),
      .en       (mac_en),
      .last     (mac_last),
      .x_in     (x_q[idx_q]),
      .c_in     (c_q[idx_q]),
      .out_data (out_data)
   );

   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tdm_core
//  Description : Self-checking bench for fir_tdm_core. Two instances share
//                stimulus: A at default parameters (SHIFT=7) and B with
//                SHIFT=0. A transaction-level model predicts handshakes and
//                results; directed literals pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tdm_core;

   localparam int TAPS    = 4;
   localparam int OUT_W   = 11;
   localparam int SHIFT_A = 7;
   localparam int SHIFT_B = 0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        coef_start;
   logic        coef_valid;
   logic [7:0]  coef_data;
   logic        out_ready;
   logic        in_ready_a, busy_a, out_valid_a;
   logic        in_ready_b, busy_b, out_valid_b;
   logic [10:0] out_data_a, out_data_b;

   always #5 clk = ~clk;

   fir_tdm_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .coef_start(coef_start), .coef_valid(coef_valid), .coef_data(coef_data), .busy(busy_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a));

   fir_tdm_core #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .coef_start(coef_start), .coef_valid(coef_valid), .coef_data(coef_data), .busy(busy_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b));

   int checks = 0;
   int errors = 0;

   // Transaction-level model: mode 0 idle, 1 loading coefficients, 2 computing.
   int m_mode, m_cnt, m_wptr;
   int m_x [TAPS];
   int m_c [TAPS];
   int m_pend_a, m_pend_b, m_out_a, m_out_b;
   bit m_slot;
   bit m_acc_flag;
   int cap_a [$];
   int cap_b [$];

   function automatic int shape(input int sum, input int sh);
      int v;
      int lim;
      v   = sum >>> sh;
      lim = 1 << (OUT_W - 1);
`ifdef FIR_SAT_EN
      if (v > lim - 1) v = lim - 1;
      if (v < -lim) v = -lim;
`else
      v = v & ((1 << OUT_W) - 1);
      if (v >= lim) v = v - (1 << OUT_W);
`endif
      return v;
   endfunction

   function automatic bit exp_in_ready();
      return (m_mode == 0) && !coef_start && (!m_slot || out_ready);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_wptr = 0; m_slot = 0;
      m_out_a = 0; m_out_b = 0; m_pend_a = 0; m_pend_b = 0;
      for (int k = 0; k < TAPS; k++) begin
         m_x[k] = 0;
         m_c[k] = 0;
      end
   endtask

   task automatic model_update(input bit ir);
      int sum;
      if (m_slot && out_ready) m_slot = 0;
      case (m_mode)
         0: begin
            if (coef_start) begin
               m_mode = 1;
               m_wptr = 0;
            end else if (in_valid && ir) begin
               for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
               m_x[0] = int'($signed(in_data));
               sum = 0;
               for (int k = 0; k < TAPS; k++) sum += m_x[k] * m_c[k];
               m_pend_a   = shape(sum, SHIFT_A);
               m_pend_b   = shape(sum, SHIFT_B);
               m_mode     = 2;
               m_cnt      = TAPS;
               m_acc_flag = 1;
            end
         end
         1: begin
            if (coef_valid) begin
               m_c[m_wptr] = int'($signed(coef_data));
               m_wptr++;
               if (m_wptr == TAPS) m_mode = 0;
            end
         end
         default: begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_slot  = 1;
               m_out_a = m_pend_a;
               m_out_b = m_pend_b;
               m_mode  = 0;
            end
         end
      endcase
   endtask

   // One clock: compare all outputs mid-cycle, then advance the model.
   task automatic step();
      bit ir;
      @(negedge clk);
      ir = exp_in_ready();
      check("in_ready_a", int'(in_ready_a), int'(ir));
      check("in_ready_b", int'(in_ready_b), int'(ir));
      check("busy_a", int'(busy_a), int'(m_mode != 0));
      check("out_valid_a", int'(out_valid_a), int'(m_slot));
      check("out_valid_b", int'(out_valid_b), int'(m_slot));
      check("out_data_a", int'($signed(out_data_a)), m_out_a);
      check("out_data_b", int'($signed(out_data_b)), m_out_b);
      if (m_slot && out_ready) begin
         cap_a.push_back(int'($signed(out_data_a)));
         cap_b.push_back(int'($signed(out_data_b)));
      end
      @(posedge clk);
      m_acc_flag = 0;
      if (!rst_n) model_reset();
      else model_update(ir);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_data = '0; coef_start = 0; coef_valid = 0; coef_data = '0; out_ready = 1;
   endtask

   task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
      int cs [TAPS];
      cs = '{c0, c1, c2, c3};
      coef_start = 1;
      step();
      coef_start = 0;
      for (int k = 0; k < TAPS; k++) begin
         coef_valid = 1;
         coef_data  = 8'(cs[k]);
         step();
      end
      coef_valid = 0;
   endtask

   task automatic send(input int v);
      bit done;
      done     = 0;
      in_valid = 1;
      in_data  = 8'(v);
      for (int t = 0; t < 40 && !done; t++) begin
         step();
         if (m_acc_flag) done = 1;
      end
      in_valid = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=notaccepted required=accepted");
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 60 && (m_mode != 0 || m_slot); t++) step();
      step();
   endtask

   task automatic async_reset();
      coef_start = 0;
      rst_n = 0;
      #1;
      model_reset();
      check("rst_busy", int'(busy_a), 0);
      check("rst_out_valid", int'(out_valid_a), 0);
      check("rst_out_data", int'(out_data_b), 0);
      check("rst_in_ready", int'(in_ready_a), 1);
      step();
      step();
      rst_n = 1;
      step();
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      model_reset();
      m_acc_flag = 0;
      step();
      step();
      rst_n = 1;
      step();
      // Reset state.
      check("init_out_valid", int'(out_valid_a), 0);
      check("init_out_data", int'(out_data_a), 0);
      check("init_in_ready", int'(in_ready_a), 1);
      check("init_busy", int'(busy_a), 0);

      // Impulse response (instance B, SHIFT=0) and latency.
      load_coefs(1, 2, 3, 4);
      cap_a.delete(); cap_b.delete();
      send(1);
      repeat (3) step();
      check("lat_pre", int'(out_valid_b), 0);
      step();
      check("lat_post", int'(out_valid_b), 1);
      send(0); send(0); send(0);
      drain();
      check("imp_n", cap_b.size(), 4);
      check("imp_0", cap_b[0], 1);
      check("imp_1", cap_b[1], 2);
      check("imp_2", cap_b[2], 3);
      check("imp_3", cap_b[3], 4);

      // Unit coefficients at SHIFT=7 (instance A).
      load_coefs(1, 1, 1, 1);
      cap_a.delete(); cap_b.delete();
      repeat (4) send(127);
      repeat (4) send(-128);
      drain();
      check("ones_n", cap_a.size(), 8);
      check("ones_0", cap_a[0], 0);
      check("ones_1", cap_a[1], 1);
      check("ones_2", cap_a[2], 2);
      check("ones_3", cap_a[3], 3);
      check("ones_4", cap_a[4], 1);
      check("ones_5", cap_a[5], -1);
      check("ones_6", cap_a[6], -3);
      check("ones_7", cap_a[7], -4);

      // Full-scale sum 4*127*127 = 64516 at SHIFT=0 and SHIFT=7.
      load_coefs(127, 127, 127, 127);
      cap_a.delete(); cap_b.delete();
      repeat (4) send(127);
      drain();
`ifdef FIR_SAT_EN
      check("full_b", cap_b[3], 1023);
`else
      check("full_b", cap_b[3], -1020);
`endif
      check("full_a", cap_a[3], 504);

      // Backpressure: result held, input blocked, same-cycle accept on release.
      out_ready = 0;
      send(5);
      for (int t = 0; t < 20 && !m_slot; t++) step();
      in_valid = 1;
      in_data  = 8'd9;
      repeat (5) step();
      check("bp_in_ready", int'(in_ready_b), 0);
`ifdef FIR_SAT_EN
      check("bp_data_b", int'($signed(out_data_b)), 1023);
`else
      check("bp_data_b", int'($signed(out_data_b)), -130);
`endif
      check("bp_data_a", int'($signed(out_data_a)), 382);
      out_ready = 1;
      #1;
      check("bp_release_ready", int'(in_ready_b), 1);
      step();
      check("bp_accept_busy", int'(busy_a), 1);
      in_valid = 0;
      drain();

      // coef_start wins over in_valid; partial burst then reset clears coefficients.
      coef_start = 1; in_valid = 1; in_data = 8'd77;
      #1;
      check("cs_in_ready", int'(in_ready_a), 0);
      step();
      check("cs_busy", int'(busy_a), 1);
      coef_start = 0; in_valid = 0;
      coef_valid = 1; coef_data = 8'd50;
      step(); step();
      coef_valid = 0;
      async_reset();
      cap_a.delete(); cap_b.delete();
      send(100);
      drain();
      check("zero_coef_a", cap_a[0], 0);
      check("zero_coef_b", cap_b[0], 0);

      // Reset asserted in the middle of a MAC.
      load_coefs(3, -5, 7, 2);
      send(10);
      step();
      async_reset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         in_valid   = ($urandom % 2) == 0;
         in_data    = 8'($urandom);
         out_ready  = ($urandom % 4) != 0;
         coef_start = ($urandom % 64) == 0;
         coef_valid = ($urandom % 2) == 0;
         coef_data  = 8'($urandom);
         step();
      end
      idle_inputs();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
